opcode_stream_decoder: RTL and testbench
========================================

// Module: opcode_stream_decoder
// PURPOSE
//  Sequential front half of the x86-64 decoder: scans the fetch window, strips legacy/REX prefixes,
//  resolves escapes (0F, 0F38, 0F3A) and emits one opcode record per instruction into an output FIFO.
//  Sits between the fetch byte window and the opcode-map lookup, which consumes out_opcode/out_map.
//  One prefix+opcode segment accepted per cycle; fetch advances its window by in_take_len.
// PARAMETERS
//  FETCH_BYTES  16  bytes visible in the fetch window; must be >= MAX_PREFIX+3
//  MAX_PREFIX    4  max prefix bytes (legacy+REX) before an error record is produced
//  OUT_DEPTH     4  output FIFO entries (power of two, >= 2)
// PORTS
//  clk            in   1                  clock
//  reset          in   1                  asynchronous, active-high reset
//  flush          in   1                  sync: drop FIFO contents, take nothing this cycle
//  in_valid       in   1                  window holds in_avail valid bytes
//  in_bytes       in   FETCH_BYTES*8      byte 0 at [FETCH_BYTES*8-1 -: 8]
//  in_avail       in   $clog2(FETCH_BYTES+1)  number of valid bytes from byte 0
//  in_take        out  1                  segment accepted this cycle (combinational)
//  in_take_len    out  $clog2(FETCH_BYTES+1)  bytes consumed when in_take=1, else 0
//  out_valid      out  1                  FIFO head valid
//  out_ready      in   1                  consumer pops head when out_valid&&out_ready
//  out_opcode     out  24                 opcode bytes, right-aligned, zero-padded (0F 05 -> 00_0F_05)
//  out_map        out  2                  0=1-byte,1=0F,2=0F38,3=0F3A
//  out_pfx        out  5                  {66,67,F0,F3,F2} seen
//  out_seg        out  3                  0=none,1=ES26,2=CS2E,3=SS36,4=DS3E,5=FS64,6=GS65
//  out_rex        out  4                  REX.{W,R,X,B}; 0 when out_rex_valid=0
//  out_rex_valid  out  1                  REX byte directly preceded the opcode
//  out_len        out  5                  prefix+escape+opcode byte count (= in_take_len at push)
//  out_err        out  1                  prefix overflow record
// BEHAVIOUR
//  Reset: FIFO empty; out_valid=0, all out_* fields 0; in_take=0, in_take_len=0.
//  Scan (comb): p = count of leading bytes in {26,2E,36,3E,64,65,66,67,F0,F2,F3,40-4F}.
//   e = escape bytes: byte[p]==0F -> (byte[p+1]==38|3A ? 2 : 1), else 0. len = p+e+1.
//  Accept: in_take=1 iff in_valid && !flush && len<=in_avail && (count<OUT_DEPTH || pop this cycle).
//   Needs-more-bytes (len>in_avail) is a stall, not an error: in_take=0, nothing pushed.
//  Prefix overflow: if p>MAX_PREFIX and in_avail>=MAX_PREFIX+1 -> push record out_err=1,
//   out_len=MAX_PREFIX+1, out_opcode=0, out_map=0, other fields from those bytes; take MAX_PREFIX+1.
//  REX: valid only if byte[p-1] in 40-4F; an earlier REX (e.g. 48 66 89) is ignored, counted in p.
//  Conflicts: later segment prefix wins; F2/F3 last-one-wins (other bit cleared); 66/67/F0 sticky.
//  Latency: record pushed at the accept edge, out_valid visible next cycle (1-cycle latency).
//  FIFO: push+pop same cycle when full is legal, count unchanged; pointers wrap mod OUT_DEPTH.
//   Outputs driven from head entry; head held stable while out_valid && !out_ready.
//  flush: count<=0, pointers<=0 next edge; a pop in the flush cycle is ignored; in_take forced 0.
//  reset asserted mid-operation: FIFO cleared immediately, in-flight segment discarded.
// TESTING
//  Window 48 89 E5 .., avail=3 -> in_take_len=2, next cycle out_opcode=000089, rex=8, rex_valid=1, len=2.
//  Window 0F 05, avail=1 -> in_take=0 stall; avail=2 -> take 2, out_opcode=000F05, map=1.
//  Window 66 48 0F 3A 0F, avail=5 -> take 5, map=3, opcode=0F3A0F, pfx[66]=1, rex_valid=1.
//  Window 48 66 89 -> len=3, rex_valid=0, rex=0, pfx[66]=1; window 66x5 -> err=1, len=5.
//  out_ready=0, 4 records pushed -> in_take=0 on 5th; out_ready=1 same cycle -> take+pop, count stays 4.
//  flush with 3 entries and out_ready=1 -> next cycle out_valid=0; reset mid-stream -> all outputs 0.

Source files
------------

// File: rtl/opcode_stream_decoder.sv
// x86-64 prefix/escape scanner feeding a small opcode record FIFO.
// One prefix+opcode segment is accepted per cycle from the fetch window.
package opcode_stream_decoder_pkg;

  typedef struct packed {
    logic [23:0] opcode;
    logic [1:0]  map;
    logic [4:0]  pfx;
    logic [2:0]  seg;
    logic [3:0]  rex;
    logic        rex_valid;
    logic [4:0]  len;
    logic        err;
  } op_rec_t;

endpackage

module opcode_stream_decoder
  import opcode_stream_decoder_pkg::*;
#(
  parameter int FETCH_BYTES = 16,
  parameter int MAX_PREFIX  = 4,
  parameter int OUT_DEPTH   = 4,
  localparam int AW = $clog2(FETCH_BYTES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [FETCH_BYTES*8-1:0] in_bytes,
  input  logic [AW-1:0]            in_avail,
  output logic                     in_take,
  output logic [AW-1:0]            in_take_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [23:0]              out_opcode,
  output logic [1:0]               out_map,
  output logic [4:0]               out_pfx,
  output logic [2:0]               out_seg,
  output logic [3:0]               out_rex,
  output logic                     out_rex_valid,
  output logic [4:0]               out_len,
  output logic                     out_err
);

  localparam int SCAN = MAX_PREFIX + 4;
  localparam int PW   = $clog2(OUT_DEPTH);
  localparam int CW   = $clog2(OUT_DEPTH + 1);

  function automatic logic is_pfx(input logic [7:0] b);
    return (b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
                      8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3}) ||
           (b[7:4] == 4'h4);
  endfunction

  logic [7:0] win_b [SCAN];
  logic [7:0] b_cur;
  logic [7:0] b0, b1, b2;
  logic       run;
  logic       ovf;
  int         p_i;
  int         len_i;
  op_rec_t    rec;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  op_rec_t       mem [OUT_DEPTH];
  op_rec_t       head;
  logic          push, pop;

  // Bytes past the fetch window read as zero so escape lookahead stays in range.
  always_comb begin
    for (int i = 0; i < SCAN; i++) begin
      win_b[i] = 8'h00;
      if (i < FETCH_BYTES)
        win_b[i] = in_bytes[(FETCH_BYTES-1-i)*8 +: 8];
    end
  end

  always_comb begin
    p_i = 0;
    run = 1'b1;
    for (int i = 0; i <= MAX_PREFIX; i++) begin
      if (run && is_pfx(win_b[i]))
        p_i = p_i + 1;
      else
        run = 1'b0;
    end
    ovf = (p_i > MAX_PREFIX);
  end

  always_comb begin
    rec   = '0;
    b_cur = 8'h00;
    for (int i = 0; i <= MAX_PREFIX; i++) begin
      if (i < p_i) begin
        b_cur = win_b[i];
        if (b_cur[7:4] == 4'h4) begin
          rec.rex       = b_cur[3:0];
          rec.rex_valid = 1'b1;
        end else begin
          rec.rex       = 4'h0;
          rec.rex_valid = 1'b0;
          unique case (b_cur)
            8'h26: rec.seg = 3'd1;
            8'h2E: rec.seg = 3'd2;
            8'h36: rec.seg = 3'd3;
            8'h3E: rec.seg = 3'd4;
            8'h64: rec.seg = 3'd5;
            8'h65: rec.seg = 3'd6;
            8'h66: rec.pfx[4] = 1'b1;
            8'h67: rec.pfx[3] = 1'b1;
            8'hF0: rec.pfx[2] = 1'b1;
            8'hF3: begin
              rec.pfx[1] = 1'b1;
              rec.pfx[0] = 1'b0;
            end
            8'hF2: begin
              rec.pfx[0] = 1'b1;
              rec.pfx[1] = 1'b0;
            end
            default: ;
          endcase
        end
      end
    end

    b0 = win_b[p_i];
    b1 = win_b[p_i+1];
    b2 = win_b[p_i+2];
    if (ovf) begin
      len_i = MAX_PREFIX + 1;
      rec.err = 1'b1;
    end else if (b0 == 8'h0F && b1 == 8'h38) begin
      len_i = p_i + 3;
      rec.map = 2'd2;
      rec.opcode = {b0, b1, b2};
    end else if (b0 == 8'h0F && b1 == 8'h3A) begin
      len_i = p_i + 3;
      rec.map = 2'd3;
      rec.opcode = {b0, b1, b2};
    end else if (b0 == 8'h0F) begin
      len_i = p_i + 2;
      rec.map = 2'd1;
      rec.opcode = {8'h00, b0, b1};
    end else begin
      len_i = p_i + 1;
      rec.opcode = {16'h0000, b0};
    end
    rec.len = 5'(len_i);
  end

  assign out_valid = (count != '0);
  assign pop  = out_valid && out_ready && !flush;
  assign push = in_take;

  assign in_take = !reset && in_valid && !flush &&
                   (len_i <= int'(in_avail)) &&
                   ((count < CW'(OUT_DEPTH)) || pop);
  assign in_take_len = in_take ? AW'(len_i) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: every output is masked by out_valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rec;
  end

  assign head = mem[rd_ptr];

  assign out_opcode    = out_valid ? head.opcode    : '0;
  assign out_map       = out_valid ? head.map       : '0;
  assign out_pfx       = out_valid ? head.pfx       : '0;
  assign out_seg       = out_valid ? head.seg       : '0;
  assign out_rex       = out_valid ? head.rex       : '0;
  assign out_rex_valid = out_valid ? head.rex_valid : 1'b0;
  assign out_len       = out_valid ? head.len       : '0;
  assign out_err       = out_valid ? head.err       : 1'b0;

endmodule

// File: tb/tb_opcode_stream_decoder.sv
// Directed bench for opcode_stream_decoder.
// Hand-computed records checked per scenario task.
module tb_opcode_stream_decoder;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [127:0] in_bytes;
  logic [4:0]   in_avail;
  logic         in_take;
  logic [4:0]   in_take_len;
  logic         out_valid;
  logic         out_ready;
  logic [23:0]  out_opcode;
  logic [1:0]   out_map;
  logic [4:0]   out_pfx;
  logic [2:0]   out_seg;
  logic [3:0]   out_rex;
  logic         out_rex_valid;
  logic [4:0]   out_len;
  logic         out_err;

  int vecs = 0;
  int errs = 0;

  logic [45:0] obs;
  logic [5:0]  tk;

  assign obs = {out_valid, out_opcode, out_map, out_pfx, out_seg,
                out_rex, out_rex_valid, out_len, out_err};
  assign tk  = {in_take, in_take_len};

  opcode_stream_decoder dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_bytes(in_bytes), .in_avail(in_avail),
    .in_take(in_take), .in_take_len(in_take_len),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_map(out_map), .out_pfx(out_pfx),
    .out_seg(out_seg), .out_rex(out_rex),
    .out_rex_valid(out_rex_valid), .out_len(out_len),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic offer(input logic [39:0] b, input logic [4:0] a);
    @(negedge clk);
    in_bytes = {b, 88'h0};
    in_avail = a;
    in_valid = 1'b1;
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_bytes = {8'h90, 120'h0};
    in_avail = 5'd1;
    #12;
    vecs++;
    if (obs !== 46'h0) begin
      errs++;
      $display("FAIL reset_out got=%h exp=0", obs);
    end
    vecs++;
    if (tk !== 6'h0) begin
      errs++;
      $display("FAIL reset_take got=%h exp=0", tk);
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_rex_mov();
    offer(40'h4889E50000, 5'd3);
    vecs++;
    if (tk !== {1'b1, 5'd2}) begin
      errs++;
      $display("FAIL rex_take got=%h exp=%h", tk, {1'b1, 5'd2});
    end
    settle();
    vecs++;
    if (obs !== {1'b1, 24'h000089, 2'd0, 5'b0, 3'd0, 4'h8, 1'b1, 5'd2, 1'b0}) begin
      errs++;
      $display("FAIL rex_rec got=%h", obs);
    end
    pop1();
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL rex_pop got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_escape();
    offer(40'h0F05000000, 5'd1);
    vecs++;
    if (tk !== 6'h0) begin
      errs++;
      $display("FAIL esc_stall got=%h exp=0", tk);
    end
    settle();
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL esc_nopush got=%b exp=0", out_valid);
    end
    offer(40'h0F05000000, 5'd2);
    vecs++;
    if (tk !== {1'b1, 5'd2}) begin
      errs++;
      $display("FAIL esc_take got=%h exp=%h", tk, {1'b1, 5'd2});
    end
    settle();
    vecs++;
    if (obs !== {1'b1, 24'h000F05, 2'd1, 5'b0, 3'd0, 4'h0, 1'b0, 5'd2, 1'b0}) begin
      errs++;
      $display("FAIL esc_rec got=%h", obs);
    end
    pop1();
  endtask

  task automatic test_three_byte();
    offer(40'h66480F3A0F, 5'd5);
    vecs++;
    if (tk !== {1'b1, 5'd5}) begin
      errs++;
      $display("FAIL esc3_take got=%h exp=%h", tk, {1'b1, 5'd5});
    end
    settle();
    vecs++;
    if (obs !== {1'b1, 24'h0F3A0F, 2'd3, 5'b10000, 3'd0, 4'h8, 1'b1, 5'd5, 1'b0}) begin
      errs++;
      $display("FAIL esc3_rec got=%h", obs);
    end
    pop1();
    offer(40'h480F383000, 5'd4);
    settle();
    vecs++;
    if (obs !== {1'b1, 24'h0F3830, 2'd2, 5'b0, 3'd0, 4'h8, 1'b1, 5'd4, 1'b0}) begin
      errs++;
      $display("FAIL esc38_rec got=%h", obs);
    end
    pop1();
  endtask

  task automatic test_rex_not_last();
    offer(40'h4866890000, 5'd3);
    vecs++;
    if (tk !== {1'b1, 5'd3}) begin
      errs++;
      $display("FAIL rexnl_take got=%h exp=%h", tk, {1'b1, 5'd3});
    end
    settle();
    vecs++;
    if (obs !== {1'b1, 24'h000089, 2'd0, 5'b10000, 3'd0, 4'h0, 1'b0, 5'd3, 1'b0}) begin
      errs++;
      $display("FAIL rexnl_rec got=%h", obs);
    end
    pop1();
  endtask

  task automatic test_overflow();
    offer(40'h6666666666, 5'd4);
    vecs++;
    if (tk !== 6'h0) begin
      errs++;
      $display("FAIL ovf_stall got=%h exp=0", tk);
    end
    offer(40'h6666666666, 5'd5);
    vecs++;
    if (tk !== {1'b1, 5'd5}) begin
      errs++;
      $display("FAIL ovf_take got=%h exp=%h", tk, {1'b1, 5'd5});
    end
    settle();
    vecs++;
    if (obs !== {1'b1, 24'h0, 2'd0, 5'b10000, 3'd0, 4'h0, 1'b0, 5'd5, 1'b1}) begin
      errs++;
      $display("FAIL ovf_rec got=%h", obs);
    end
    pop1();
  endtask

  task automatic test_conflicts();
    offer(40'h2664F3F290, 5'd5);
    settle();
    vecs++;
    if (obs !== {1'b1, 24'h000090, 2'd0, 5'b00001, 3'd5, 4'h0, 1'b0, 5'd5, 1'b0}) begin
      errs++;
      $display("FAIL conf_a got=%h", obs);
    end
    pop1();
    offer(40'hF2F32E3E90, 5'd5);
    settle();
    vecs++;
    if (obs !== {1'b1, 24'h000090, 2'd0, 5'b00010, 3'd4, 4'h0, 1'b0, 5'd5, 1'b0}) begin
      errs++;
      $display("FAIL conf_b got=%h", obs);
    end
    pop1();
    offer(40'h67F0419000, 5'd6);
    settle();
    vecs++;
    if (obs !== {1'b1, 24'h000090, 2'd0, 5'b01100, 3'd0, 4'h1, 1'b1, 5'd4, 1'b0}) begin
      errs++;
      $display("FAIL conf_c got=%h", obs);
    end
    pop1();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer({8'(8'h90 + k), 32'h0}, 5'd1);
      vecs++;
      if (tk !== {1'b1, 5'd1}) begin
        errs++;
        $display("FAIL fill_take%0d got=%h exp=%h", k, tk, {1'b1, 5'd1});
      end
    end
    offer({8'h94, 32'h0}, 5'd1);
    vecs++;
    if (tk !== 6'h0) begin
      errs++;
      $display("FAIL full_stall got=%h exp=0", tk);
    end
    out_ready = 1'b1;
    #1;
    vecs++;
    if (tk !== {1'b1, 5'd1}) begin
      errs++;
      $display("FAIL full_pushpop got=%h exp=%h", tk, {1'b1, 5'd1});
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_bytes = {8'h95, 120'h0};
    #1;
    vecs++;
    if ({tk, out_opcode} !== {6'h0, 24'h000091}) begin
      errs++;
      $display("FAIL full_hold got=%h exp=%h", {tk, out_opcode}, {6'h0, 24'h000091});
    end
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      vecs++;
      if ({out_valid, out_opcode} !== {1'b1, 24'(8'h90 + k)}) begin
        errs++;
        $display("FAIL drain%0d got=%h exp=%h", k, {out_valid, out_opcode}, {1'b1, 24'(8'h90 + k)});
      end
      pop1();
    end
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL drain_empty got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++)
      offer({8'(8'h90 + k), 32'h0}, 5'd1);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    in_bytes = {8'h93, 120'h0};
    #1;
    vecs++;
    if (tk !== 6'h0) begin
      errs++;
      $display("FAIL flush_take got=%h exp=0", tk);
    end
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    #1;
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_empty got=%b exp=0", out_valid);
    end
    offer({8'h96, 32'h0}, 5'd1);
    settle();
    vecs++;
    if ({out_valid, out_opcode} !== {1'b1, 24'h000096}) begin
      errs++;
      $display("FAIL flush_next got=%h exp=%h", {out_valid, out_opcode}, {1'b1, 24'h000096});
    end
    pop1();
  endtask

  task automatic test_reset_mid();
    offer({8'h90, 32'h0}, 5'd1);
    offer({8'h91, 32'h0}, 5'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    vecs++;
    if ({obs, tk} !== 52'h0) begin
      errs++;
      $display("FAIL rstmid_out got=%h exp=0", {obs, tk});
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    vecs++;
    if (obs !== 46'h0) begin
      errs++;
      $display("FAIL rstmid_after got=%h exp=0", obs);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_bytes = '0;
    in_avail = '0;
    out_ready = 1'b0;
    test_reset();
    test_rex_mov();
    test_escape();
    test_three_byte();
    test_rex_not_last();
    test_overflow();
    test_conflicts();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
